// File: rtl/mux_pkg.sv
// Shared constants and select-decode helpers for the one-hot pixel selector.
package mux_pkg;

  localparam int MUX_N     = 9;
  localparam int MUX_WIDTH = 24;
  localparam int MUX_ERR_W = 8;
  localparam int MUX_MAX_N = 32;

  function automatic logic is_onehot(input logic [MUX_MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // Returns 0 for an all-zero vector; callers qualify with v != 0.
  function automatic logic [4:0] lowest_set(input logic [MUX_MAX_N-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MUX_MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready register (main + skid) giving full throughput under back-pressure.
module pipe_skid_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             skid_full
);

  // Handshake: a word moves on any edge where valid && ready are both 1; valid
  // never depends on ready, and in_ready is a register equal to !skid_full.
  logic             main_valid, main_valid_n;
  logic [WIDTH-1:0] main_data, main_data_n;
  logic             skid_valid, skid_valid_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             ready_r;
  logic             accept, drain;

  assign accept = in_valid && ready_r;
  assign drain  = main_valid && out_ready;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (drain || !main_valid) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_r    <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      ready_r    <= !skid_valid_n;
    end
  end

  assign in_ready  = ready_r;
  assign out_data  = main_data;
  assign out_valid = main_valid;
  assign skid_full = skid_valid;

endmodule

// File: rtl/mux_onehot_pipe.sv
// Pipelined one-hot channel selector with non-one-hot error counting.
// Build option: MUX_ONEHOT_PRIO_EN resolves multi-hot selects to the lowest set bit.
module mux_onehot_pipe
  import mux_pkg::*;
#(
  parameter int N     = MUX_N,
  parameter int WIDTH = MUX_WIDTH,
  parameter int ERR_W = MUX_ERR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_flag,
  output logic [ERR_W-1:0]   err_cnt,
  input  logic               err_clr
);

  logic [MUX_MAX_N-1:0] sel_ext;
  logic [WIDTH-1:0]     sel_word;
  logic                 bad_sel;
  logic                 skid_full;

  always_comb begin
    sel_ext        = '0;
    sel_ext[N-1:0] = in_sel;
  end

  always_comb begin
    sel_word = '0;
`ifdef MUX_ONEHOT_PRIO_EN
    if (sel_ext != '0) sel_word = in_data[int'(lowest_set(sel_ext))*WIDTH +: WIDTH];
`else
    if (is_onehot(sel_ext)) begin
      for (int k = 0; k < N; k++) begin
        if (in_sel[k]) sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
`endif
  end

  pipe_skid_reg #(.WIDTH(WIDTH)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .skid_full (skid_full)
  );

  // Only selects that actually transfer are counted.
  assign bad_sel = in_valid && in_ready && !is_onehot(sel_ext);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      err_flag <= bad_sel;
      err_cnt  <= bad_sel ? ERR_W'(1) : '0;
    end else if (bad_sel) begin
      err_flag <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_onehot_pipe.sv
// Bench for mux_onehot_pipe: directed scenarios plus random traffic against a queue model.
module tb_mux_onehot_pipe;

  localparam int N = 9;
  localparam int W = 24;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_sel;
  logic           in_valid;
  logic           in_ready, in_ready2;
  logic [W-1:0]   out_data, out_data2;
  logic           out_valid, out_valid2;
  logic           out_ready;
  logic           err_flag, err_flag2;
  logic [7:0]     err_cnt;
  logic [1:0]     err_cnt2;
  logic           err_clr;

  int checks = 0;
  int errors = 0;

  mux_onehot_pipe #(.N(N), .WIDTH(W), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_flag(err_flag),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  mux_onehot_pipe #(.N(N), .WIDTH(W), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_flag(err_flag2),
    .err_cnt(err_cnt2), .err_clr(err_clr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  function automatic logic [W-1:0] ref_word(input logic [N*W-1:0] d, input logic [N-1:0] s);
    logic [N-1:0] low;
    int idx;
    ref_word = '0;
    low = s & (~s + 9'd1);
`ifdef MUX_ONEHOT_PRIO_EN
    if (s != '0) begin
      idx = $clog2(low);
      ref_word = d[idx*W +: W];
    end
`else
    if ($countones(s) == 1) begin
      idx = $clog2(s);
      ref_word = d[idx*W +: W];
    end
`endif
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_ready = 1'b0;
  logic         exp_flag = 1'b0;
  int           exp_cnt = 0;
  int           exp_cnt2 = 0;
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL mon_in_ready t=%0t got %b exp %b", $time, in_ready, exp_ready);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL mon_out_valid t=%0t got %b exp %b", $time, out_valid, exp_q.size() != 0);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL mon_out_data t=%0t got %h exp %h", $time, out_data, exp_q[0]);
        end
      end
      checks++;
      if (err_flag !== exp_flag || err_cnt !== 8'(exp_cnt) || err_cnt2 !== 2'(exp_cnt2)) begin
        errors++;
        $display("FAIL mon_err t=%0t got flag=%b cnt=%0d cnt2=%0d exp flag=%b cnt=%0d cnt2=%0d",
                 $time, err_flag, err_cnt, err_cnt2, exp_flag, exp_cnt, exp_cnt2);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      exp_ready = 1'b0;
      exp_flag  = 1'b0;
      exp_cnt   = 0;
      exp_cnt2  = 0;
      mon_en    = 1'b1;
    end else if (mon_en) begin
      bit bad;
      bad = in_valid && in_ready && ($countones(in_sel) != 1);
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(ref_word(in_data, in_sel));
      if (err_clr) begin
        exp_flag = bad;
        exp_cnt  = bad ? 1 : 0;
        exp_cnt2 = bad ? 1 : 0;
      end else if (bad) begin
        exp_flag = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      exp_ready = (exp_q.size() < 2);
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_input(input logic [N-1:0] sel);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
    in_sel   = sel;
    in_valid = 1'b1;
  endtask

  function automatic logic [N-1:0] rand_bad_sel();
    logic [N-1:0] s;
    s = N'($urandom);
    while ($countones(s) == 1) s = N'($urandom);
    return s;
  endfunction

  task automatic idle_drain(input int n);
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 || err_flag !== 1'b0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b data=%h ready=%b flag=%b cnt=%0d exp 0 0 0 0 0",
               out_valid, out_data, in_ready, err_flag, err_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise got %b exp 1", in_ready);
    end
    out_ready = 1'b1;
    set_input(9'b000000100);
    in_data[2*W +: W] = 24'hABCDEF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hABCDEF || err_cnt !== '0) begin
      errors++;
      $display("FAIL first_word got valid=%b data=%h cnt=%0d exp 1 abcdef 0", out_valid, out_data, err_cnt);
    end
    idle_drain(2);
  endtask

  task automatic test_stream;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_input(N'(1) << k);
      exp = in_data[k*W +: W];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ch%0d got valid=%b data=%h ready=%b exp 1 %h 1", k, out_valid, out_data, in_ready, exp);
      end
    end
    idle_drain(2);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w[3];
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_input(N'(1) << $urandom_range(0, N-1));
      w[i] = ref_word(in_data, in_sel);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 2 || in_ready !== 1'b0 || out_data !== w[0]) begin
      errors++;
      $display("FAIL bp_fill got acc=%0d ready=%b data=%h exp 2 0 %h", acc, in_ready, out_data, w[0]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== w[1]) begin
      errors++; $display("FAIL bp_second got valid=%b data=%h exp 1 %h", out_valid, out_data, w[1]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
    idle_drain(1);
  endtask

  task automatic test_bad_sel;
    logic [W-1:0] exp;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    out_ready = 1'b1;
    set_input(9'b000000000);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++; $display("FAIL bad_zero got valid=%b data=%h exp 1 000000", out_valid, out_data);
    end
    set_input(9'b000000011);
`ifdef MUX_ONEHOT_PRIO_EN
    exp = in_data[0 +: W];
`else
    exp = '0;
`endif
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++; $display("FAIL bad_multi got valid=%b data=%h exp 1 %h", out_valid, out_data, exp);
    end
    checks++;
    if (err_flag !== 1'b1 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL bad_count got flag=%b cnt=%0d exp 1 2", err_flag, err_cnt);
    end
    idle_drain(1);
  endtask

  task automatic test_saturate;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_input(rand_bad_sel());
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 8'd7 || err_flag2 !== 1'b1) begin
      errors++; $display("FAIL sat_count got cnt2=%0d cnt=%0d flag2=%b exp 3 7 1", err_cnt2, err_cnt, err_flag2);
    end
    set_input(rand_bad_sel());
    err_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    checks++;
    if (err_cnt2 !== 2'd1 || err_cnt !== 8'd1 || err_flag !== 1'b1 || err_flag2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_err got cnt=%0d cnt2=%0d flag=%b flag2=%b exp 1 1 1 1", err_cnt, err_cnt2, err_flag, err_flag2);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== '0 || err_flag !== 1'b0) begin
      errors++; $display("FAIL clr_only got cnt=%0d flag=%b exp 0 0", err_cnt, err_flag);
    end
    idle_drain(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) set_input(rand_bad_sel());
        else set_input(N'(1) << $urandom_range(0, N-1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_drain(4);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_input(N'(1) << $urandom_range(0, N-1));
      tick();
    end
    set_input(rand_bad_sel());
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got ready=%b valid=%b exp 0 1", in_ready, out_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_cnt !== '0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b ready=%b cnt=%0d flag=%b exp 0 0 0 0", out_valid, in_ready, err_cnt, err_flag);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale cycle=%0d got valid=%b exp 0", i, out_valid);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready got %b exp 1", in_ready);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_bad_sel();
    test_saturate();
    test_random();
    test_reset_mid();
    idle_drain(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_drain got %0d words left exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_onehot_pipe.md
# mux_onehot_pipe

Parametrised, pipelined one-hot selector for the pixel path. It picks one of N WIDTH-bit channels (default 9 × 24-bit RGB) under a one-hot select. The selected word passes through a registered valid/ready stage with a skid buffer, so it runs at full throughput under back-pressure. Non-one-hot selects are detected, forced to a defined output, and counted for debug. It sits between the per-source pixel generators and the display/frame writer.

## Interface
- N, 9: number of input channels (2..32)
- WIDTH, 24: data width per channel
- ERR_W, 8: width of the error counter
- clk  in  1: system clock, all logic on rising edge
- rst_n  in  1: synchronous, active-low reset
- in_data  in  N*WIDTH: packed channels; channel k at bits [k*WIDTH +: WIDTH]
- in_sel  in  N: one-hot channel select, sampled with in_valid
- in_valid  in  1: input word offered
- in_ready  out  1: block can accept
- out_data  out  WIDTH: selected word
- out_valid  out  1: out_data valid
- out_ready  in  1: downstream accepts
- err_flag  out  1: sticky, set by any accepted non-one-hot select
- err_cnt  out  ERR_W: count of accepted non-one-hot selects, saturating
- err_clr  in  1: clears err_flag and err_cnt

## Operation
- Transfer occurs on a cycle when valid and ready are both 1, at either port.
- Select resolution on accepted input:
  - Exactly one bit set: output is that channel.
  - Otherwise: see Configuration.
- Storage is two entries: a main output register plus one skid register.
  - in_ready = !skid_full, registered.
  - While out_valid=1 and out_ready=0, an accepted word goes to the skid register.
  - When the output drains, the skid entry moves to main on the next cycle.
- Data order is strictly FIFO. No word is dropped or duplicated.
- Error path:
  - An accepted non-one-hot select sets err_flag and increments err_cnt.
  - err_cnt saturates at 2^ERR_W−1.
  - err_clr zeroes both registers. If err_clr and an error occur in the same cycle, the result is err_flag=1 and err_cnt=1.
- The error path ignores select values presented while in_valid=0 or in_ready=0.

## Timing
- Reset (rst_n=0 at a clock edge) gives: out_valid=0, out_data=0, err_flag=0, err_cnt=0, skid empty.
- in_ready=0 during reset and 1 on the first cycle after reset.
- Latency is 1 cycle: an input accepted at edge t appears with out_valid=1 after edge t.
- Throughput is 1 word/cycle when out_ready=1.
- in_ready falls the cycle after the skid fills and rises the cycle after the skid drains.
- If input and output transfers happen in the same cycle with the main register full, main is replaced by the new word and occupancy is unchanged.
- Reset mid-operation flushes both entries. Pending data is discarded and no output is produced for it.
- out_data holds its value while out_valid=1 and out_ready=0.
- out_data is don't-care-stable (holds its last value) when out_valid=0.

## Configuration
- MUX_ONEHOT_PRIO_EN:
  - Defined: a multi-hot select resolves to the lowest-index set bit. An all-zero select gives out_data=0.
  - Not defined: any non-one-hot select, zero or multi-hot, gives out_data=0.
- In both cases non-one-hot selects set err_flag and count in err_cnt.

## Structure
- Package mux_pkg holds:
  - Default constants MUX_N=9, MUX_WIDTH=24, MUX_ERR_W=8.
  - Function is_onehot(logic [N-1:0]).
  - Function lowest_set index.
- Sub-module pipe_skid_reg (WIDTH-parametrised two-entry valid/ready register). The select decode and error counter live in the top.

## Test plan
- Reset with rst_n=0 for 2 cycles, then in_valid=1, in_sel=9'b000000100, C=24'hABCDEF, out_ready=1 → out_valid=1 and out_data=24'hABCDEF one cycle later; err_cnt=0.
- Stream channels A..I with one-hot selects, out_ready=1 → 9 outputs back-to-back in order, in_ready stays 1.
- out_ready=0 with in_valid held high and 3 words offered → 2 accepted, in_ready=0. Release out_ready → both words emerge in order with no loss, and in_ready returns to 1.
- Selects 9'b0 and 9'b000000011 accepted:
  - Without the macro: both outputs are 0.
  - With MUX_ONEHOT_PRIO_EN: outputs are 0 and A.
  - In both cases err_flag=1 and err_cnt=2.
- ERR_W=2, 5 bad selects → err_cnt saturates at 3. err_clr together with a bad select → err_cnt=1, err_flag=1.
- Assert rst_n=0 with both entries full → next cycle out_valid=0, in_ready=0, err_cnt=0, and no stale word appears after reset.
